// File: rtl/cpu_ctrl_pkg.sv
// Shared types and encodings for the multicycle RV32I control FSM.
package cpu_ctrl_pkg;

  localparam int unsigned OPCODE_W = 7;
  localparam int unsigned ALU_OP_W = 4;
  localparam int unsigned SEL_W    = 2;

  typedef enum logic [3:0] {
    FETCH, DECODE, EXEC_R, EXEC_I, MEM_ADDR, MEM_RD, MEM_WR,
    WB_ALU, WB_MEM, BRANCH, JAL, LUI, HALT
  } state_t;

  localparam logic [OPCODE_W-1:0] OP_RTYPE  = 7'b0110011;
  localparam logic [OPCODE_W-1:0] OP_ITYPE  = 7'b0010011;
  localparam logic [OPCODE_W-1:0] OP_LOAD   = 7'b0000011;
  localparam logic [OPCODE_W-1:0] OP_STORE  = 7'b0100011;
  localparam logic [OPCODE_W-1:0] OP_BRANCH = 7'b1100011;
  localparam logic [OPCODE_W-1:0] OP_JAL    = 7'b1101111;
  localparam logic [OPCODE_W-1:0] OP_LUI    = 7'b0110111;
  localparam logic [OPCODE_W-1:0] OP_SYSTEM = 7'b1110011;

  typedef enum logic [ALU_OP_W-1:0] {
    ALU_ADD  = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR  = 4'd3,
    ALU_XOR  = 4'd4, ALU_SLT = 4'd5, ALU_SLTU = 4'd6, ALU_SLL = 4'd7,
    ALU_SRL  = 4'd8, ALU_SRA = 4'd9
  } alu_op_t;

  localparam logic [SEL_W-1:0] PC_SRC_PLUS4  = 2'd0;
  localparam logic [SEL_W-1:0] PC_SRC_TARGET = 2'd1;
  localparam logic [SEL_W-1:0] PC_SRC_HOLD   = 2'd2;

  localparam logic [SEL_W-1:0] WB_SEL_ALU  = 2'd0;
  localparam logic [SEL_W-1:0] WB_SEL_MEM  = 2'd1;
  localparam logic [SEL_W-1:0] WB_SEL_PC4  = 2'd2;
  localparam logic [SEL_W-1:0] WB_SEL_UIMM = 2'd3;

  localparam logic ALU_A_PC  = 1'b0;
  localparam logic ALU_A_RS1 = 1'b1;

  localparam logic [SEL_W-1:0] ALU_B_RS2  = 2'd0;
  localparam logic [SEL_W-1:0] ALU_B_FOUR = 2'd1;
  localparam logic [SEL_W-1:0] ALU_B_IMM  = 2'd2;

  // States that own the memory port and are subject to the timeout.
  function automatic logic is_mem_state(input state_t s);
    return (s == FETCH) || (s == MEM_RD) || (s == MEM_WR);
  endfunction

endpackage

// File: rtl/ctrl_alu_decode.sv
// ALU function select from funct3/funct7b5; funct7b5 only matters for SUB (R-type) and SRA.
module ctrl_alu_decode
  import cpu_ctrl_pkg::*;
(
  input  logic [2:0]          funct3,
  input  logic                funct7b5,
  input  logic                is_rtype,
  output logic [ALU_OP_W-1:0] alu_op
);

  always_comb begin
    alu_op = ALU_ADD;
    case (funct3)
      3'b000:  alu_op = (is_rtype && funct7b5) ? ALU_SUB : ALU_ADD;
      3'b001:  alu_op = ALU_SLL;
      3'b010:  alu_op = ALU_SLT;
      3'b011:  alu_op = ALU_SLTU;
      3'b100:  alu_op = ALU_XOR;
      3'b101:  alu_op = funct7b5 ? ALU_SRA : ALU_SRL;
      3'b110:  alu_op = ALU_OR;
      default: alu_op = ALU_AND;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32I-subset control FSM sequencing a shared pc/memory/regfile/ALU datapath.
module multicycle_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [6:0]          opcode,
  input  logic [2:0]          funct3,
  input  logic                funct7b5,
  input  logic                zero,
  input  logic                mem_ready,
  output logic                mem_read,
  output logic                mem_write,
  output logic                iord,
  output logic                ir_write,
  output logic                pc_write,
  output logic [1:0]          pc_src,
  output logic                reg_write,
  output logic [1:0]          wb_sel,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [3:0]          alu_op,
  output logic                halted,
  output logic                fault,
  output logic [CNT_W-1:0]    instr_count
);

  localparam int unsigned TW = $clog2(MEM_TIMEOUT + 1);

  state_t              state, state_next;
  logic [TW-1:0]       tcnt;
  logic                timeout_c, taken_c, retire_c, fault_set_c;
  logic [ALU_OP_W-1:0] dec_alu_op;

  ctrl_alu_decode u_alu_decode (
    .funct3   (funct3),
    .funct7b5 (funct7b5),
    .is_rtype (opcode == OP_RTYPE),
    .alu_op   (dec_alu_op)
  );

  // A ready on the final counted cycle completes rather than times out.
  assign timeout_c = is_mem_state(state) && !mem_ready && (tcnt == TW'(MEM_TIMEOUT - 1));
  assign taken_c   = ((funct3 == 3'b000) && zero) || ((funct3 == 3'b001) && !zero);

  always_ff @(posedge clk) begin
    if (reset) state <= FETCH;
    else       state <= state_next;
  end

  always_comb begin
    state_next  = state;
    retire_c    = 1'b0;
    fault_set_c = 1'b0;
    case (state)
      FETCH: begin
        if (mem_ready)      state_next = DECODE;
        else if (timeout_c) begin state_next = HALT; fault_set_c = 1'b1; end
      end
      DECODE: begin
        case (opcode)
          OP_RTYPE:          state_next = EXEC_R;
          OP_ITYPE:          state_next = EXEC_I;
          OP_LOAD, OP_STORE: state_next = MEM_ADDR;
          OP_BRANCH:         state_next = BRANCH;
          OP_JAL:            state_next = JAL;
          OP_LUI:            state_next = LUI;
          OP_SYSTEM:         state_next = HALT;
          default: begin state_next = HALT; fault_set_c = 1'b1; end
        endcase
      end
      EXEC_R, EXEC_I: state_next = WB_ALU;
      MEM_ADDR:       state_next = (opcode == OP_STORE) ? MEM_WR : MEM_RD;
      MEM_RD: begin
        if (mem_ready)      state_next = WB_MEM;
        else if (timeout_c) begin state_next = HALT; fault_set_c = 1'b1; end
      end
      MEM_WR: begin
        if (mem_ready)      begin state_next = FETCH; retire_c = 1'b1; end
        else if (timeout_c) begin state_next = HALT; fault_set_c = 1'b1; end
      end
      WB_ALU, WB_MEM, JAL, LUI: begin
        state_next = FETCH;
        retire_c   = 1'b1;
      end
      BRANCH: begin
        if ((funct3 == 3'b000) || (funct3 == 3'b001)) begin
          state_next = FETCH;
          retire_c   = 1'b1;
        end else begin
          state_next  = HALT;
          fault_set_c = 1'b1;
        end
      end
      HALT:    state_next = HALT;
      default: begin state_next = HALT; fault_set_c = 1'b1; end
    endcase
  end

  // Wait counter restarts whenever the FSM changes state.
  always_ff @(posedge clk) begin
    if (reset || (state_next != state))      tcnt <= '0;
    else if (is_mem_state(state) && !mem_ready) tcnt <= tcnt + TW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fault       <= 1'b0;
      instr_count <= '0;
    end else begin
      if (fault_set_c) fault       <= 1'b1;
      if (retire_c)    instr_count <= instr_count + CNT_W'(1);
    end
  end

  // Output decode; reset forces the idle pattern within the same cycle.
  always_comb begin
    mem_read  = 1'b0;
    mem_write = 1'b0;
    iord      = 1'b0;
    ir_write  = 1'b0;
    pc_write  = 1'b0;
    pc_src    = PC_SRC_HOLD;
    reg_write = 1'b0;
    wb_sel    = WB_SEL_ALU;
    alu_src_a = ALU_A_PC;
    alu_src_b = ALU_B_RS2;
    alu_op    = ALU_ADD;
    halted    = 1'b0;
    if (!reset) begin
      case (state)
        FETCH: begin
          mem_read  = 1'b1;
          alu_src_b = ALU_B_FOUR;
          if (mem_ready) begin
            ir_write = 1'b1;
            pc_write = 1'b1;
            pc_src   = PC_SRC_PLUS4;
          end
        end
        DECODE:   alu_src_b = ALU_B_IMM;
        EXEC_R: begin
          alu_src_a = ALU_A_RS1;
          alu_op    = dec_alu_op;
        end
        EXEC_I: begin
          alu_src_a = ALU_A_RS1;
          alu_src_b = ALU_B_IMM;
          alu_op    = dec_alu_op;
        end
        MEM_ADDR: begin
          alu_src_a = ALU_A_RS1;
          alu_src_b = ALU_B_IMM;
        end
        MEM_RD: begin
          mem_read = 1'b1;
          iord     = 1'b1;
        end
        MEM_WR: begin
          mem_write = 1'b1;
          iord      = 1'b1;
        end
        WB_ALU:   reg_write = 1'b1;
        WB_MEM: begin
          reg_write = 1'b1;
          wb_sel    = WB_SEL_MEM;
        end
        BRANCH: begin
          alu_src_a = ALU_A_RS1;
          alu_op    = ALU_SUB;
          if (taken_c) begin
            pc_write = 1'b1;
            pc_src   = PC_SRC_TARGET;
          end
        end
        JAL: begin
          pc_write  = 1'b1;
          pc_src    = PC_SRC_TARGET;
          reg_write = 1'b1;
          wb_sel    = WB_SEL_PC4;
        end
        LUI: begin
          reg_write = 1'b1;
          wb_sel    = WB_SEL_UIMM;
        end
        HALT:     halted = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: directed scenarios plus randomized instruction stream
// checked against a per-instruction latency/strobe model.
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        funct7b5, zero, mem_ready;
  logic        mem_read, mem_write, iord, ir_write, pc_write, reg_write;
  logic [1:0]  pc_src, wb_sel, alu_src_b;
  logic        alu_src_a, halted, fault;
  logic [3:0]  alu_op;
  logic [31:0] instr_count;

  int          vectors     = 0;
  int          miscompares = 0;
  int unsigned model_count = 0;

  multicycle_ctrl #(.MEM_TIMEOUT(16), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3), .funct7b5(funct7b5),
    .zero(zero), .mem_ready(mem_ready), .mem_read(mem_read), .mem_write(mem_write),
    .iord(iord), .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
    .reg_write(reg_write), .wb_sel(wb_sel), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .halted(halted), .fault(fault), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Instruction classes: 0=R 1=I 2=load 3=store 4=branch 5=jal 6=lui
  function automatic logic [6:0] op_of(input int cls);
    case (cls)
      0: return 7'h33;
      1: return 7'h13;
      2: return 7'h03;
      3: return 7'h23;
      4: return 7'h63;
      5: return 7'h6F;
      default: return 7'h37;
    endcase
  endfunction

  function automatic int base_lat(input int cls);
    case (cls)
      0, 1, 3: return 4;
      2:       return 5;
      default: return 3;
    endcase
  endfunction

  function automatic logic [3:0] exp_alu(input int cls, input logic [2:0] f3, input logic f7);
    case (f3)
      3'd0: return (cls == 0 && f7) ? 4'd1 : 4'd0;
      3'd1: return 4'd7;
      3'd2: return 4'd5;
      3'd3: return 4'd6;
      3'd4: return 4'd4;
      3'd5: return f7 ? 4'd9 : 4'd8;
      3'd6: return 4'd3;
      default: return 4'd2;
    endcase
  endfunction

  // Runs one legal instruction; wf/wm are wait cycles on fetch/data access, zf: 0/1 fixed, 2 random.
  task automatic run_instr(input int cls, input logic [2:0] f3, input logic f7,
                           input int zf, input int wf, input int wm);
    bit          is_mem = (cls == 2) || (cls == 3);
    int          lat = base_lat(cls) + wf + (is_mem ? wm : 0);
    int          n_ir = 0, n_pcw = 0, n_rd = 0, n_wr = 0, n_io = 0, n_rw = 0;
    logic [1:0]  wb_obs = 2'd0, sb_obs = 2'd0, sb_dec = 2'd0, last_pcs = 2'd0, exp_wb;
    logic [3:0]  alu_obs = 4'd0;
    logic        sa_obs = 1'b0, zero_br = 1'b0, last_pcw = 1'b0, last_rw = 1'b0;
    bit          redirect, writes;
    for (int idx = 0; idx < lat; idx++) begin
      reset    = 1'b0;
      opcode   = op_of(cls);
      funct3   = f3;
      funct7b5 = f7;
      zero     = (zf == 2) ? 1'($urandom_range(0, 1)) : 1'(zf);
      if (idx < wf)                                    mem_ready = 1'b0;
      else if (idx == wf)                              mem_ready = 1'b1;
      else if (is_mem && idx >= wf + 3 && idx < wf + 3 + wm) mem_ready = 1'b0;
      else if (is_mem && idx == wf + 3 + wm)           mem_ready = 1'b1;
      else                                             mem_ready = 1'($urandom_range(0, 1));
      #1;
      if (idx == 0) begin
        chk("fetch_mem_read", 32'(mem_read), 32'd1);
        chk("fetch_iord", 32'(iord), 32'd0);
        chk("fetch_src_b", 32'(alu_src_b), 32'd1);
      end
      if (idx == wf + 1) sb_dec = alu_src_b;
      if (idx == wf + 2) begin
        alu_obs = alu_op; sa_obs = alu_src_a; sb_obs = alu_src_b; zero_br = zero;
      end
      n_ir  += int'(ir_write);
      n_pcw += int'(pc_write);
      n_rd  += int'(mem_read);
      n_wr  += int'(mem_write);
      n_io  += int'(iord && (mem_read || mem_write));
      n_rw  += int'(reg_write);
      if (reg_write) wb_obs = wb_sel;
      if (idx == lat - 1) begin
        last_pcw = pc_write; last_pcs = pc_src; last_rw = reg_write;
      end
      tick();
    end
    redirect = (cls == 5) || (cls == 4 && ((f3 == 3'd0 && zero_br) || (f3 == 3'd1 && !zero_br)));
    writes   = (cls <= 2) || (cls == 5) || (cls == 6);
    exp_wb   = (cls == 2) ? 2'd1 : (cls == 5) ? 2'd2 : (cls == 6) ? 2'd3 : 2'd0;
    model_count++;
    chk("ir_write_count", 32'(n_ir), 32'd1);
    chk("mem_read_count", 32'(n_rd), 32'(wf + 1 + ((cls == 2) ? wm + 1 : 0)));
    chk("mem_write_count", 32'(n_wr), 32'((cls == 3) ? wm + 1 : 0));
    chk("iord_count", 32'(n_io), 32'(is_mem ? wm + 1 : 0));
    chk("reg_write_count", 32'(n_rw), 32'(writes));
    chk("reg_write_last", 32'(last_rw), 32'(writes));
    if (writes) chk("wb_sel", 32'(wb_obs), 32'(exp_wb));
    chk("pc_write_count", 32'(n_pcw), 32'(1 + int'(redirect)));
    chk("pc_write_last", 32'(last_pcw), 32'(redirect));
    if (redirect) chk("pc_src_target", 32'(last_pcs), 32'd1);
    chk("decode_src_b", 32'(sb_dec), 32'd2);
    if (cls <= 1) begin
      chk("exec_alu_op", 32'(alu_obs), 32'(exp_alu(cls, f3, f7)));
      chk("exec_src_a", 32'(sa_obs), 32'd1);
      chk("exec_src_b", 32'(sb_obs), 32'((cls == 0) ? 0 : 2));
    end else if (cls == 4) begin
      chk("branch_alu_op", 32'(alu_obs), 32'd1);
      chk("branch_src_a", 32'(sa_obs), 32'd1);
      chk("branch_src_b", 32'(sb_obs), 32'd0);
    end else if (is_mem) begin
      chk("addr_alu_op", 32'(alu_obs), 32'd0);
      chk("addr_src_a", 32'(sa_obs), 32'd1);
      chk("addr_src_b", 32'(sb_obs), 32'd2);
    end
    chk("instr_count", instr_count, 32'(model_count));
    chk("no_fault", 32'(fault), 32'd0);
    chk("not_halted", 32'(halted), 32'd0);
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    mem_ready = 1'b0;
    #1;
    chk("reset_strobes", 32'({mem_read, mem_write, ir_write, pc_write, reg_write}), 32'd0);
    tick();
    chk("reset_fault", 32'(fault), 32'd0);
    chk("reset_count", instr_count, 32'd0);
    model_count = 0;
  endtask

  // Instruction expected to halt after 'pre' cycles.
  task automatic halt_instr(input logic [6:0] op, input logic [2:0] f3, input int pre,
                            input logic exp_fault);
    for (int idx = 0; idx < pre; idx++) begin
      reset = 1'b0; opcode = op; funct3 = f3; funct7b5 = 1'b0;
      zero      = 1'($urandom_range(0, 1));
      mem_ready = (idx == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      #1;
      chk("pre_halt", 32'(halted), 32'd0);
      tick();
    end
    for (int idx = 0; idx < 4; idx++) begin
      mem_ready = 1'($urandom_range(0, 1));
      #1;
      chk("halted", 32'(halted), 32'd1);
      chk("halt_fault", 32'(fault), 32'(exp_fault));
      chk("halt_strobes", 32'({mem_read, mem_write, ir_write, pc_write, reg_write}), 32'd0);
      chk("halt_count", instr_count, 32'(model_count));
      tick();
    end
    do_reset();
  endtask

  initial begin
    int cls, wf, wm;
    logic [2:0] f3;
    reset = 1'b1; opcode = 7'h0; funct3 = 3'd0; funct7b5 = 1'b0; zero = 1'b0; mem_ready = 1'b1;
    tick();
    tick();
    chk("rst_mem_read", 32'(mem_read), 32'd0);
    chk("rst_ir_write", 32'(ir_write), 32'd0);
    chk("rst_pc_write", 32'(pc_write), 32'd0);
    chk("rst_pc_src", 32'(pc_src), 32'd2);
    chk("rst_src_b", 32'(alu_src_b), 32'd0);
    chk("rst_alu_op", 32'(alu_op), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_fault", 32'(fault), 32'd0);
    chk("rst_count", instr_count, 32'd0);

    run_instr(0, 3'd0, 1'b0, 2, 0, 0);   // add x3,x1,x2
    run_instr(4, 3'd0, 1'b0, 1, 0, 0);   // beq taken
    run_instr(4, 3'd0, 1'b0, 0, 0, 0);   // beq not taken
    run_instr(4, 3'd1, 1'b0, 0, 0, 0);   // bne taken
    run_instr(2, 3'd2, 1'b0, 2, 0, 3);   // lw, 3 wait cycles
    run_instr(3, 3'd2, 1'b0, 2, 1, 2);   // sw
    run_instr(0, 3'd0, 1'b1, 2, 0, 0);   // sub
    run_instr(1, 3'd5, 1'b1, 2, 0, 0);   // srai
    run_instr(1, 3'd0, 1'b1, 2, 0, 0);   // addi ignores funct7b5
    run_instr(5, 3'd0, 1'b0, 2, 2, 0);   // jal
    run_instr(6, 3'd0, 1'b0, 2, 0, 0);   // lui
    run_instr(0, 3'd4, 1'b0, 2, 15, 0);  // ready on last allowed fetch cycle
    run_instr(3, 3'd2, 1'b0, 2, 0, 15);  // ready on last allowed store cycle

    for (int n = 0; n < 40; n++) begin
      cls = int'($urandom_range(0, 6));
      f3  = (cls == 4) ? 3'($urandom_range(0, 1)) : 3'($urandom_range(0, 7));
      wf  = ($urandom_range(0, 7) == 0) ? 15 : int'($urandom_range(0, 3));
      wm  = ($urandom_range(0, 7) == 0) ? 15 : int'($urandom_range(0, 3));
      run_instr(cls, f3, 1'($urandom_range(0, 1)), 2, wf, wm);
    end

    halt_instr(7'h7F, 3'd0, 2, 1'b1);  // illegal opcode
    halt_instr(7'h73, 3'd0, 2, 1'b0);  // ecall/ebreak: clean halt
    halt_instr(7'h63, 3'd2, 3, 1'b1);  // unsupported branch funct3

    // Fetch timeout.
    for (int idx = 0; idx < 16; idx++) begin
      reset = 1'b0; opcode = 7'h33; mem_ready = 1'b0;
      #1;
      chk("fetch_wait_read", 32'(mem_read), 32'd1);
      chk("fetch_wait_quiet", 32'({halted, ir_write, pc_write}), 32'd0);
      tick();
    end
    chk("fetch_to_halted", 32'(halted), 32'd1);
    chk("fetch_to_fault", 32'(fault), 32'd1);
    for (int idx = 0; idx < 50; idx++) begin
      mem_ready = 1'($urandom_range(0, 1));
      #1;
      chk("to_stay_halted", 32'(halted), 32'd1);
      chk("to_no_ir_write", 32'(ir_write), 32'd0);
      tick();
    end
    do_reset();

    // Load data-phase timeout.
    opcode = 7'h03;
    for (int idx = 0; idx < 3; idx++) begin
      reset = 1'b0; mem_ready = (idx == 0);
      #1;
      tick();
    end
    for (int idx = 0; idx < 16; idx++) begin
      mem_ready = 1'b0;
      #1;
      chk("rd_wait_req", 32'({mem_read, iord}), 32'd3);
      chk("rd_wait_quiet", 32'({halted, reg_write}), 32'd0);
      tick();
    end
    chk("rd_to_halted", 32'(halted), 32'd1);
    chk("rd_to_fault", 32'(fault), 32'd1);
    chk("rd_to_count", instr_count, 32'd0);
    do_reset();

    // Reset in the middle of a store wait.
    run_instr(0, 3'd0, 1'b0, 2, 0, 0);
    opcode = 7'h23;
    for (int idx = 0; idx < 4; idx++) begin
      reset = 1'b0; mem_ready = (idx == 0);
      #1;
      if (idx == 3) chk("wr_wait_write", 32'(mem_write), 32'd1);
      tick();
    end
    reset = 1'b1; mem_ready = 1'b0;
    #1;
    chk("wr_reset_write", 32'(mem_write), 32'd0);
    chk("wr_reset_iord", 32'(iord), 32'd0);
    tick();
    chk("wr_reset_count", instr_count, 32'd0);
    chk("wr_reset_fault", 32'(fault), 32'd0);
    reset = 1'b0;
    #1;
    chk("wr_reset_fetch", 32'({mem_read, iord}), 32'd2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
